wor_bus_arbiter: RTL and testbench



---
 rtl/wor_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_wor_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wor_bus_arbiter.sv
// Round-robin owner of a shared wired-OR result bus: bounded bursts per owner and a
// one-cycle idle gap between owners so two drivers never overlap on the net.
module wor_bus_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    grant,
   output logic [DW-1:0]      bus_data,
   output logic               bus_valid,
   output logic               busy
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [DW-1:0]   bus_data_q, bus_data_d;
   logic            bus_valid_q, bus_valid_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   int              cand;

   // Scan from ptr upward with wrap; iterating backwards lets the closest hit win.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = (int'(ptr_q) + k) % NREQ;
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = PW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      bus_data_d  = bus_data_q;
      bus_valid_d = bus_valid_q;
      case (state_q)
         S_IDLE: begin
            grant_d     = '0;
            bus_data_d  = '0;
            bus_valid_d = 1'b0;
            if (win_found) begin
               grant_d = NREQ'(1) << win_idx;
               owner_d = win_idx;
               cnt_d   = '0;
               state_d = S_OWN;
            end
         end
         S_OWN: begin
            if (req[owner_q] && (cnt_q < CW'(MAX_BURST))) begin
               bus_data_d  = req_data[int'(owner_q)*DW +: DW];
               bus_valid_d = 1'b1;
               cnt_d       = cnt_q + CW'(1);
            end else begin
               grant_d     = '0;
               bus_data_d  = '0;
               bus_valid_d = 1'b0;
               ptr_d       = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
               state_d     = S_GAP;
            end
         end
         S_GAP: begin
            grant_d     = '0;
            bus_data_d  = '0;
            bus_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: begin
            grant_d     = '0;
            bus_data_d  = '0;
            bus_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         grant_q     <= '0;
         bus_data_q  <= '0;
         bus_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         bus_data_q  <= bus_data_d;
         bus_valid_q <= bus_valid_d;
      end
   end

   assign grant     = grant_q;
   assign bus_data  = bus_data_q;
   assign bus_valid = bus_valid_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wor_bus_arbiter.sv
// Bench for wor_bus_arbiter: two instances (burst 4 and burst 1) driven by directed and
// random request patterns and compared each cycle against a transaction-level model.
module tb_wor_bus_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req0, req1;
   logic [63:0] rd0, rd1;
   logic [3:0]  grant0, grant1;
   logic [15:0] bd0, bd1;
   logic        bv0, bv1, busy0, busy1;

   logic [3:0]  rq  [2];
   logic [15:0] dat [2][4];

   int own   [2];
   int beats [2];
   int hold  [2];
   int ptr   [2];
   int maxb  [2];
   logic [3:0]  exp_grant [2];
   logic [15:0] exp_data  [2];
   logic        exp_valid [2];
   logic        exp_busy  [2];

   int n_vec = 0;
   int n_err = 0;
   bit fix_a5 = 1'b0;

   always #5 clk = ~clk;

   assign req0 = rq[0];
   assign req1 = rq[1];
   assign rd0  = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
   assign rd1  = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};

   wor_bus_arbiter #(.NREQ(4), .DW(16), .MAX_BURST(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .req_data(rd0),
      .grant(grant0), .bus_data(bd0), .bus_valid(bv0), .busy(busy0)
   );

   wor_bus_arbiter #(.NREQ(4), .DW(16), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .req_data(rd1),
      .grant(grant1), .bus_data(bd1), .bus_valid(bv1), .busy(busy1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         own[k] = -1; beats[k] = 0; hold[k] = 0; ptr[k] = 0;
         exp_grant[k] = '0; exp_data[k] = '0; exp_valid[k] = 1'b0; exp_busy[k] = 1'b0;
      end
   endtask

   // Outputs after the coming rising edge, given the inputs now applied.
   task automatic model_step(input int k);
      int c;
      if (own[k] >= 0) begin
         if (rq[k][own[k]] && beats[k] < maxb[k]) begin
            exp_valid[k] = 1'b1;
            exp_data[k]  = dat[k][own[k]];
            beats[k]++;
         end else begin
            exp_grant[k] = '0; exp_valid[k] = 1'b0; exp_data[k] = '0;
            ptr[k]  = (own[k] + 1) % 4;
            own[k]  = -1;
            hold[k] = 1;
         end
      end else if (hold[k] > 0) begin
         hold[k]--;
         exp_grant[k] = '0; exp_valid[k] = 1'b0; exp_data[k] = '0;
      end else begin
         exp_grant[k] = '0; exp_valid[k] = 1'b0; exp_data[k] = '0;
         for (int i = 0; i < 4; i++) begin
            c = (ptr[k] + i) % 4;
            if (own[k] < 0 && rq[k][c]) own[k] = c;
         end
         if (own[k] >= 0) begin
            beats[k] = 0;
            exp_grant[k] = 4'b0001 << own[k];
         end
      end
      exp_busy[k] = (own[k] >= 0) || (hold[k] > 0);
   endtask

   task automatic check_all();
      logic [3:0]  g [2];
      logic [15:0] d [2];
      logic        v [2];
      logic        b [2];
      g[0] = grant0; g[1] = grant1; d[0] = bd0; d[1] = bd1;
      v[0] = bv0;    v[1] = bv1;    b[0] = busy0; b[1] = busy1;
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("grant%0d", k), 32'(g[k]), 32'(exp_grant[k]));
         check_val($sformatf("bus_valid%0d", k), 32'(v[k]), 32'(exp_valid[k]));
         check_val($sformatf("bus_data%0d", k), 32'(d[k]), 32'(exp_data[k]));
         check_val($sformatf("busy%0d", k), 32'(b[k]), 32'(exp_busy[k]));
         check_val($sformatf("onehot%0d", k), 32'($onehot0(g[k])), 32'd1);
         check_val($sformatf("valid_needs_grant%0d", k), 32'(v[k] && (g[k] == '0)), 32'd0);
      end
   endtask

   // Called at a falling edge: apply inputs, predict, then check at the next falling edge.
   task automatic step(input logic [3:0] r0, input logic [3:0] r1);
      rq[0] = r0;
      rq[1] = r1;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++)
            dat[k][i] = 16'($urandom);
      if (fix_a5) dat[0][2] = 16'hA5C3;
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_all();
   endtask

   // Asynchronous reset in the middle of a low clock phase, checked before any edge.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] r [2];
      maxb[0] = 4;
      maxb[1] = 1;
      rst_n = 1'b0;
      rq[0] = '0;
      rq[1] = '0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++)
            dat[k][i] = '0;
      model_reset();
      @(negedge clk);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester 2 with a fixed word; instance 1 alternates 0/1 single beats.
      fix_a5 = 1'b1;
      for (int n = 0; n < 11; n++) step(4'b0100, 4'b0011);
      fix_a5 = 1'b0;
      check_val("t1_beat3_data", 32'(bd0), 32'h0000A5C3);

      // Reset lands during beat 3 of owner 2; restart searches from requester 0.
      pulse_reset();
      for (int n = 0; n < 8; n++) step(4'b0110, 4'b0011);

      // All requesting: strict rotation with one idle cycle between owners.
      pulse_reset();
      for (int n = 0; n < 40; n++) step(4'b1111, 4'b0011);

      // Owner 1 drops after two beats while 3 waits, then 3/0 wrap-around with 1001.
      pulse_reset();
      step(4'b1010, 4'b0011);
      step(4'b1010, 4'b0011);
      step(4'b1010, 4'b0011);
      for (int n = 0; n < 8; n++) step(4'b1000, 4'b0011);
      for (int n = 0; n < 16; n++) step(4'b1001, 4'b0011);

      // Random request levels with persistence so bursts of varied length occur.
      r[0] = 4'($urandom);
      r[1] = 4'($urandom);
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++)
               if ($urandom_range(0, 3) == 0) r[k][i] = ~r[k][i];
         step(r[0], r[1]);
         if (n == 300) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
